// File: rtl/net_edge_pkg.sv
// Shared types and constants for the two-net edge recorder.
package net_edge_pkg;

    localparam int DEF_TS_W = 16;

    localparam logic [1:0] SRC_J    = 2'b01;
    localparam logic [1:0] SRC_K    = 2'b10;
    localparam logic [1:0] SRC_BOTH = 2'b11;

    typedef struct packed {
        logic [1:0]          src;
        logic [DEF_TS_W-1:0] ts;
    } evt_rec_t;

endpackage

// File: rtl/net_edge_fifo.sv
// First-word-fall-through FIFO of event records; head is read straight from storage.
// Latency: a pushed record reaches the head one cycle later (no bypass).
// Backpressure: push taken when not full or when a pop happens the same cycle; pop ignored when empty.
module net_edge_fifo
    import net_edge_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type rec_t = evt_rec_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push,
    input  rec_t                   wr_dat,
    input  logic                   pop,
    output rec_t                   rd_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    rec_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    // One extra pointer bit tells full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rd_dat  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/net_edge_recorder.sv
// Timestamps rising edges on two async nets and queues {src, ts} records for a valid/ready consumer.
// Latency: 2 cycles from first capture of an input change to evt_valid_o.
// Backpressure: full FIFO without a same-cycle pop drops the event, sets overflow and counts it.
module net_edge_recorder
    import net_edge_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TS_W   = DEF_TS_W,
    parameter int DROP_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   j_i,
    input  logic                   k_i,
    output logic                   evt_valid_o,
    input  logic                   evt_ready_i,
    output logic [1:0]             evt_src_o,
    output logic [TS_W-1:0]        evt_ts_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overflow_o,
    output logic [DROP_W-1:0]      drop_cnt_o,
    input  logic                   clear_i
);
    typedef struct packed {
        logic [1:0]      src;
        logic [TS_W-1:0] ts;
    } rec_t;

    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      hist;
    logic [1:0]      rise;
    logic [TS_W-1:0] ts_q;
    logic            evt;
    logic            pop;
    logic            push;
    logic            drop;
    logic            full;
    logic            empty;
    rec_t            wr_rec;
    rec_t            head;

    // Bit 0 carries j, bit 1 carries k throughout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
            ts_q  <= '0;
        end else begin
            sync1 <= {k_i, j_i};
            sync2 <= sync1;
            hist  <= sync2;
            ts_q  <= ts_q + TS_W'(1);
        end
    end

    assign rise       = sync2 & ~hist;
    assign evt        = |rise;
    assign wr_rec.src = rise;
    assign wr_rec.ts  = ts_q;

    assign pop  = evt_valid_o & evt_ready_i;
    assign push = evt & (~full | pop);
    assign drop = evt & full & ~pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (clear_i) begin
                drop_cnt_o <= DROP_W'(1);
            end else if (drop_cnt_o != '1) begin
                drop_cnt_o <= drop_cnt_o + DROP_W'(1);
            end
        end else if (clear_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end
    end

    net_edge_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .wr_dat (wr_rec),
        .pop    (pop),
        .rd_dat (head),
        .full   (full),
        .empty  (empty),
        .level  (level_o)
    );

    // Storage is not reset, so the head fields are forced to 0 while nothing is queued.
    assign evt_valid_o = ~empty;
    assign evt_src_o   = empty ? 2'b00 : head.src;
    assign evt_ts_o    = empty ? '0 : head.ts;

endmodule

// File: tb/tb_net_edge_recorder.sv
// Directed bench for net_edge_recorder: a 16-bit and a 4-bit timestamp instance share stimulus.
module tb_net_edge_recorder;
    import net_edge_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        j, k, ready, clear;

    logic        valid, valid4;
    logic [1:0]  src, src4;
    logic [15:0] ts;
    logic [3:0]  ts4;
    logic [2:0]  level, level4;
    logic        ovf, ovf4;
    logic [7:0]  dcnt, dcnt4;

    int unsigned ecnt;
    int          checks = 0;
    int          errors = 0;
    evt_rec_t    q[$];

    net_edge_recorder #(.DEPTH(4), .TS_W(16), .DROP_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .j_i(j), .k_i(k),
        .evt_valid_o(valid), .evt_ready_i(ready), .evt_src_o(src), .evt_ts_o(ts),
        .level_o(level), .overflow_o(ovf), .drop_cnt_o(dcnt), .clear_i(clear)
    );

    net_edge_recorder #(.DEPTH(4), .TS_W(4), .DROP_W(8)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .j_i(j), .k_i(k),
        .evt_valid_o(valid4), .evt_ready_i(ready), .evt_src_o(src4), .evt_ts_o(ts4),
        .level_o(level4), .overflow_o(ovf4), .drop_cnt_o(dcnt4), .clear_i(clear)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the value read between edges is the timestamp the next edge samples.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_head(input string tag);
        evt_rec_t e;
        e = q[0];
        chk({tag, "_vld"}, 32'(valid), 32'd1);
        chk({tag, "_vld4"}, 32'(valid4), 32'd1);
        chk({tag, "_src"}, 32'(src), 32'(e.src));
        chk({tag, "_ts"}, 32'(ts), 32'(e.ts));
        chk({tag, "_ts4"}, 32'(ts4), 32'(e.ts) & 32'hF);
    endtask

    task automatic check_stats(input string tag, input int lvl, input int of, input int dc);
        chk({tag, "_lvl"}, 32'(level), 32'(lvl));
        chk({tag, "_lvl4"}, 32'(level4), 32'(lvl));
        chk({tag, "_ovf"}, 32'(ovf), 32'(of));
        chk({tag, "_dcnt"}, 32'(dcnt), 32'(dc));
    endtask

    // One-cycle pulse; expected record goes to the scoreboard unless the FIFO will be full.
    task automatic pulse(input logic [1:0] which, inout int drops);
        evt_rec_t r;
        r.src = which;
        r.ts  = 16'(ecnt + 2);
        if (q.size() < 4) q.push_back(r);
        else              drops++;
        j = which[0];
        k = which[1];
        tick(1);
        j = 1'b0;
        k = 1'b0;
        tick(2);
    endtask

    task automatic drain(input string tag);
        int n;
        n = q.size();
        ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check_head(tag);
            void'(q.pop_front());
            tick(1);
        end
        ready = 1'b0;
        chk({tag, "_empty_vld"}, 32'(valid), 32'd0);
        chk({tag, "_empty_lvl"}, 32'(level), 32'd0);
    endtask

    initial begin
        evt_rec_t r;
        int drops;
        drops = 0;
        rst_n = 1'b0; j = 1'b0; k = 1'b0; ready = 1'b0; clear = 1'b0;
        tick(2);
        chk("rst_vld", 32'(valid), 32'd0);
        chk("rst_src", 32'(src), 32'd0);
        chk("rst_ts", 32'(ts), 32'd0);
        check_stats("rst", 0, 0, 0);
        rst_n = 1'b1;
        tick(2);

        // Single edge held high: exactly one record, visible after the third edge.
        r.src = SRC_J; r.ts = 16'(ecnt + 2); q.push_back(r);
        j = 1'b1;
        tick(1); chk("single_lat1", 32'(valid), 32'd0);
        tick(1); chk("single_lat2", 32'(valid), 32'd0);
        tick(1); check_head("single");
        chk("single_lvl", 32'(level), 32'd1);
        tick(4); chk("single_hold_lvl", 32'(level), 32'd1);
        check_head("single_hold");
        j = 1'b0;
        drain("single_drain");
        tick(3);

        // Coincident edges, then k alone 5 cycles later.
        r.src = SRC_BOTH; r.ts = 16'(ecnt + 2); q.push_back(r);
        j = 1'b1; k = 1'b1;
        tick(1); k = 1'b0;
        tick(4);
        r.src = SRC_K; r.ts = 16'(ecnt + 2); q.push_back(r);
        k = 1'b1;
        tick(1); k = 1'b0; j = 1'b0;
        tick(4);
        chk("coinc_lvl", 32'(level), 32'd2);
        chk("coinc_tsdiff", 32'(q[1].ts - q[0].ts), 32'd5);
        drain("coinc_drain");
        tick(3);

        // Overflow: six edges into a depth-4 FIFO with no consumer.
        for (int i = 0; i < 6; i++) pulse(SRC_J, drops);
        tick(2);
        check_stats("ovf", 4, 1, drops);
        chk("ovf_drops_model", 32'(drops), 32'd2);
        drain("ovf_drain");
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check_stats("clear", 0, 0, 0);
        tick(3);

        // Full FIFO with an event landing on the same edge as a pop.
        for (int i = 0; i < 4; i++) pulse(SRC_J, drops);
        chk("full_lvl", 32'(level), 32'd4);
        r.src = SRC_K; r.ts = 16'(ecnt + 2); q.push_back(r);
        k = 1'b1;
        tick(1); k = 1'b0;
        tick(1);
        check_head("fullpop_head");
        void'(q.pop_front());
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check_stats("fullpop", 4, 0, 0);
        chk("fullpop_last_src", 32'(q[3].src), 32'(SRC_K));
        drain("fullpop_drain");
        tick(3);

        // Events 10 cycles apart: 4-bit timestamps wrap, pointers cycle many times.
        for (int i = 0; i < 10; i++) begin
            r.src = SRC_J; r.ts = 16'(ecnt + 2); q.push_back(r);
            j = 1'b1;
            tick(1); j = 1'b0;
            tick(2);
            check_head("wrap");
            void'(q.pop_front());
            ready = 1'b1;
            tick(1);
            ready = 1'b0;
            chk("wrap_vld0", 32'(valid), 32'd0);
            tick(6);
        end

        // Reset with three records queued.
        for (int i = 0; i < 3; i++) pulse(SRC_J, drops);
        chk("prerst_lvl", 32'(level), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst_vld", 32'(valid), 32'd0);
        chk("midrst_src", 32'(src), 32'd0);
        chk("midrst_ts", 32'(ts), 32'd0);
        check_stats("midrst", 0, 0, 0);
        q.delete();
        tick(2);
        rst_n = 1'b1;
        pulse(SRC_J, drops);
        chk("postrst_ts_const", 32'(ts), 32'd2);
        check_head("postrst");
        chk("postrst_lvl", 32'(level), 32'd1);
        drain("postrst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/net_edge_recorder.md
# net_edge_recorder

Timestamping event recorder for two single-bit nets (`j`, `k`) driven by a peer block's port pair. It synchronises both inputs and detects rising edges. Each detected event is queued as a {source, timestamp} record in a small FIFO and drained through a valid/ready interface. Overflow and drop statistics are kept for the consumer.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `TS_W`, 16: timestamp width.
- `DROP_W`, 8: drop-counter width.

- `clk_i` in 1: the block's one clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `j_i` in 1: asynchronous net; a rising edge is event bit 0.
- `k_i` in 1: asynchronous net; a rising edge is event bit 1.
- `evt_valid_o` out 1: head record available.
- `evt_ready_i` in 1: consumer accepts the head record.
- `evt_src_o` out 2: head record source, {k,j}.
- `evt_ts_o` out TS_W: head record timestamp.
- `level_o` out $clog2(DEPTH)+1: number of FIFO entries occupied.
- `overflow_o` out 1: sticky; at least one event was dropped.
- `drop_cnt_o` out DROP_W: dropped events, saturating.
- `clear_i` in 1: synchronous pulse; clears `overflow_o` and `drop_cnt_o`.

## Operation
- Each input passes through its own 2-flop synchroniser, followed by a history flop. `rise = sync & ~hist`.
- An event exists in a cycle where either rise bit is 1. Its record is src = {rise_k, rise_j} and ts = current timestamp counter value.
- Coincident edges produce one record with src = 2'b11. They never produce two records.
- Timestamp counter: TS_W bits, free-running from 0 after reset, +1 every cycle, wraps to 0 with no flag.
- Push occurs when an event exists and the FIFO is not full, or when it is full and a pop happens in the same cycle.
- Pop: `evt_valid_o & evt_ready_i`.
- Drop occurs when an event exists, the FIFO is full and there is no pop. On a drop, `overflow_o` is set and `drop_cnt_o` increments, saturating at all-ones.
- `clear_i` with a simultaneous drop: the drop wins. Flag = 1, count = 1.
- FIFO is first-word-fall-through. Head outputs come straight from the storage array. Outputs are stable while `evt_valid_o` is high and `evt_ready_i` is low.
- `evt_ready_i` while `evt_valid_o` is 0 has no effect.
- Empty FIFO plus push: there is no same-cycle bypass. The record becomes visible on the next cycle.
- Read and write pointers are $clog2(DEPTH)+1 bits. Full is the MSBs differing with the rest equal; empty is the pointers equal. Wrap is natural modulo.
- Reset values:
  - All outputs are 0.
  - Pointers, timestamp counter, synchronisers, history, overflow flag and drop count are all 0.
  - Storage contents need no reset.
- Reset asserted mid-operation: all state clears immediately (asynchronously). Queued records are discarded and no pop is reported.

## Timing
- An input level change captured at edge t reaches the sync output at t+1.
- The record is written at edge t+2, holding that cycle's timestamp.
- `evt_valid_o` rises after edge t+2.
- Input-to-valid latency: 2 cycles after first capture. There are no combinational paths from `j_i`/`k_i` to outputs.
- `evt_ready_i` to pointer update: the pointer updates at the same edge. The next head is presented one cycle later.
- Throughput: one push and one pop per cycle, concurrently.
- `level_o` and `drop_cnt_o` are registered and update at the edge of the event.

## Structure
- Package `net_edge_pkg`: typedef `evt_rec_t` {src[1:0], ts}, parameterised via the default TS_W, plus `SRC_J`, `SRC_K` and `SRC_BOTH` constants.
- Sub-module `net_edge_fifo`: generic FWFT FIFO over `evt_rec_t`, with push, pop, full, empty and level.
- The top level holds the synchronisers, edge detect, timestamp counter and drop/overflow logic.

## Test plan
- Single edge: after reset, raise `j_i` and hold with `evt_ready_i`=0.
  - Exactly one record: src=2'b01, `level_o`=1.
  - `evt_valid_o` high 2 cycles after first capture.
- Coincident edges: raise `j_i` and `k_i` in the same cycle.
  - One record with src=2'b11.
  - Pulsing `k_i` again 5 cycles later gives a second record with src=2'b10 and ts difference 5.
- Overflow, DEPTH=4, `evt_ready_i`=0: generate 6 separated `j_i` edges.
  - `level_o`=4, `overflow_o`=1, `drop_cnt_o`=2.
  - Drain: the 4 oldest timestamps come out in order.
  - Then pulse `clear_i`: flag and count return to 0.
- Full plus simultaneous pop: FIFO full, event arrives in the same cycle as a pop.
  - No drop; `level_o` stays 4.
  - The new record appears last in drain order.
- Wrap: set TS_W=4 and generate events 10 cycles apart across a counter wrap.
  - Timestamps are taken modulo 16 (e.g. 12 then 6).
  - Pointers wrap correctly over more than 2×DEPTH push/pop cycles.
- Reset mid-stream: assert `rst_ni` low with 3 records queued.
  - All outputs go to 0 immediately.
  - After release, no stale record appears and the timestamp restarts at 0.
